// File: rtl/scaled_window_gen.sv
// scaled_window_gen: maps the HDMI raster position onto a centred, integer-scaled
// GBA window. It produces the draw strobe, the sub-pixel phases, the line-cache
// read address and handshakes, and the HDMI enable / frame-resync state.
//
// Optional feature macro: RESYNC_STATS_EN (adds resyncCount).
//
// Ports:
//   pxlClk       pixel clock, rising edge
//   rst          asynchronous active-low reset
//   cx, cy       HDMI raster position
//   frameWidth   total raster width incl. blanking
//   frameHeight  total raster height incl. blanking
//   scaleSel     requested scale minus 1 (taken at frame end)
//   sameLine     cache already holds the current line, suppresses nextLine
//   newFrameIn   GBA new-frame level
//   drawWin      pixel lies inside the scaled window (LOCKED only)
//   subX, subY   horizontal / vertical phase within a source pixel
//   curPxl       line-cache read address (leads the window by PREFETCH)
//   nextLine     one-cycle request to advance the source line
//   cacheUpdate  one-cycle cache rotate strobe at the window's right edge
//   hdmiEnable   HDMI core enable
//   activeScale  scale currently in effect
//   resyncCount  saturating LOCKED->RESYNC count (RESYNC_STATS_EN only)
module scaled_window_gen #(
  parameter int SRC_W         = 240,
  parameter int SRC_H         = 160,
  parameter int FRAME_W       = 1280,
  parameter int FRAME_H       = 720,
  parameter int MAX_SCALE     = 4,
  parameter int DEFAULT_SCALE = 3,
  parameter int PREFETCH      = 3,
  parameter int RESYNC_HOLD   = 16
) (
  input  logic        pxlClk,
  input  logic        rst,
  input  logic [11:0] cx,
  input  logic [10:0] cy,
  input  logic [11:0] frameWidth,
  input  logic [10:0] frameHeight,
  input  logic [2:0]  scaleSel,
  input  logic        sameLine,
  input  logic        newFrameIn,
  output logic        drawWin,
  output logic [2:0]  subX,
  output logic [2:0]  subY,
  output logic [7:0]  curPxl,
  output logic        nextLine,
  output logic        cacheUpdate,
  output logic        hdmiEnable,
  output logic [3:0]  activeScale
`ifdef RESYNC_STATS_EN
  ,
  output logic [7:0]  resyncCount
`endif
);

  localparam int unsigned HOLD_W = (RESYNC_HOLD > 1) ? $clog2(RESYNC_HOLD) : 1;

  typedef enum logic [1:0] {IDLE, LOCKED, RESYNC} stateT;

  // Window bounds for a given scale, centred in the active frame.
  function automatic logic [11:0] calcXStart(input logic [3:0] s);
    calcXStart = 12'((FRAME_W - int'(s) * SRC_W) / 2);
  endfunction

  function automatic logic [11:0] calcXStop(input logic [3:0] s);
    calcXStop = calcXStart(s) + 12'(int'(s) * SRC_W);
  endfunction

  function automatic logic [10:0] calcYStart(input logic [3:0] s);
    calcYStart = 11'((FRAME_H - int'(s) * SRC_H) / 2);
  endfunction

  function automatic logic [10:0] calcYStop(input logic [3:0] s);
    calcYStop = calcYStart(s) + 11'(int'(s) * SRC_H);
  endfunction

  logic [11:0]       xStart, xStop;
  logic [10:0]       yStart, yStop;
  logic [2:0]        pfPhase;
  logic              nfDel;
  stateT             state, stateNext;
  logic [HOLD_W-1:0] holdCnt, holdCntNext;
  logic              hdmiEnableNext;

  logic              lineEnd, frameEnd, rise;
  logic              inX, inY, pfClear, yAligned;
  logic [2:0]        scaleM1;
  logic [3:0]        scaleReq, scaleNew;

  // Raster decode against the bounds in effect for this frame.
  assign lineEnd  = (cx == frameWidth - 12'd1);
  assign frameEnd = lineEnd && (cy == frameHeight - 11'd1);
  assign rise     = newFrameIn && !nfDel;
  assign scaleM1  = 3'(activeScale - 4'd1);
  assign scaleReq = {1'b0, scaleSel} + 4'd1;
  assign scaleNew = (scaleReq > 4'(MAX_SCALE)) ? 4'(MAX_SCALE) : scaleReq;
  assign inX      = (cx >= xStart) && (cx < xStop);
  assign inY      = (cy >= yStart) && (cy < yStop);
  assign pfClear  = (cx <= xStart - 12'(PREFETCH)) || (cx > xStop - 12'(PREFETCH));
  // GBA frame start may land on the first window line or the one before it.
  assign yAligned = (cy == yStart) || (cy == yStart - 11'd1);

  // Scale and window bounds only move at frame end.
  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      activeScale <= 4'(DEFAULT_SCALE);
      xStart      <= calcXStart(4'(DEFAULT_SCALE));
      xStop       <= calcXStop(4'(DEFAULT_SCALE));
      yStart      <= calcYStart(4'(DEFAULT_SCALE));
      yStop       <= calcYStop(4'(DEFAULT_SCALE));
    end else if (frameEnd) begin
      activeScale <= scaleNew;
      xStart      <= calcXStart(scaleNew);
      xStop       <= calcXStop(scaleNew);
      yStart      <= calcYStart(scaleNew);
      yStop       <= calcYStop(scaleNew);
    end
  end

  // Per-pixel datapath: draw strobe, phases, cache address and handshakes.
  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      nfDel       <= 1'b0;
      drawWin     <= 1'b0;
      subX        <= 3'd0;
      subY        <= 3'd0;
      pfPhase     <= 3'd0;
      curPxl      <= 8'd0;
      cacheUpdate <= 1'b0;
      nextLine    <= 1'b0;
    end else begin
      nfDel   <= newFrameIn;
      drawWin <= inX && inY && (state == LOCKED);

      if (cx == xStart || subX == scaleM1) begin
        subX <= 3'd0;
      end else begin
        subX <= subX + 3'd1;
      end

      if (lineEnd) begin
        if (frameEnd || subY == scaleM1) begin
          subY <= 3'd0;
        end else if (cy >= yStart) begin
          subY <= subY + 3'd1;
        end
      end

      // Address runs PREFETCH cycles ahead of the window and saturates at the last pixel.
      if (pfClear) begin
        pfPhase <= 3'd0;
        curPxl  <= 8'd0;
      end else if (pfPhase == scaleM1) begin
        pfPhase <= 3'd0;
        if (curPxl != 8'(SRC_W - 1)) begin
          curPxl <= curPxl + 8'd1;
        end
      end else begin
        pfPhase <= pfPhase + 3'd1;
      end

      cacheUpdate <= (cx == xStop);
      nextLine    <= (cx == xStop) && !sameLine && inY && (subY == scaleM1);
    end
  end

  // Frame-lock FSM state register.
  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      holdCnt    <= '0;
      hdmiEnable <= 1'b0;
    end else begin
      state      <= stateNext;
      holdCnt    <= holdCntNext;
      hdmiEnable <= hdmiEnableNext;
    end
  end

  // Frame-lock FSM next state; a misaligned frame start forces a timed resync.
  always_comb begin
    stateNext      = state;
    holdCntNext    = holdCnt;
    hdmiEnableNext = 1'b0;
    case (state)
      IDLE: begin
        if (rise) stateNext = LOCKED;
      end
      LOCKED: begin
        if (rise && !yAligned) begin
          stateNext   = RESYNC;
          holdCntNext = '0;
        end
      end
      RESYNC: begin
        holdCntNext = holdCnt + HOLD_W'(1);
        if (holdCnt == HOLD_W'(RESYNC_HOLD - 1)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    hdmiEnableNext = (stateNext == LOCKED);
  end

`ifdef RESYNC_STATS_EN
  // Saturating count of lock losses.
  always_ff @(posedge pxlClk or negedge rst) begin
    if (!rst) begin
      resyncCount <= 8'd0;
    end else if (state == LOCKED && stateNext == RESYNC && resyncCount != 8'hFF) begin
      resyncCount <= resyncCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_scaled_window_gen.sv
// Directed bench for scaled_window_gen: raster position is driven directly (jumping
// between points of interest) so full 720p frames are not needed.
`timescale 1ns/1ps
module tb_scaled_window_gen;

  logic        pxlClk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] cx = 12'd0;
  logic [10:0] cy = 11'd0;
  logic [11:0] frameWidth = 12'd1650;
  logic [10:0] frameHeight = 11'd750;
  logic [2:0]  scaleSel = 3'd2;
  logic        sameLine = 1'b0;
  logic        newFrameIn = 1'b0;
  logic        drawWin, nextLine, cacheUpdate, hdmiEnable;
  logic [2:0]  subX, subY;
  logic [7:0]  curPxl;
  logic [3:0]  activeScale;
`ifdef RESYNC_STATS_EN
  logic [7:0]  resyncCount;
`endif

  int checks = 0;
  int failures = 0;

  always #5 pxlClk = ~pxlClk;

  scaled_window_gen dut (
    .pxlClk      (pxlClk),
    .rst         (rst),
    .cx          (cx),
    .cy          (cy),
    .frameWidth  (frameWidth),
    .frameHeight (frameHeight),
    .scaleSel    (scaleSel),
    .sameLine    (sameLine),
    .newFrameIn  (newFrameIn),
    .drawWin     (drawWin),
    .subX        (subX),
    .subY        (subY),
    .curPxl      (curPxl),
    .nextLine    (nextLine),
    .cacheUpdate (cacheUpdate),
    .hdmiEnable  (hdmiEnable),
    .activeScale (activeScale)
`ifdef RESYNC_STATS_EN
    ,
    .resyncCount (resyncCount)
`endif
  );

  // Present a raster position, clock it, and sample just after the edge.
  task automatic tick(input int x, input int y);
    cx = 12'(x);
    cy = 11'(y);
    @(posedge pxlClk);
    #1;
  endtask

  task automatic frameEndTick();
    tick(int'(frameWidth) - 1, int'(frameHeight) - 1);
  endtask

  // Expected read address: clear outside the prefetch span, one step per scale cycles.
  function automatic int expCurPxl(input int c, input int xs, input int xe, input int s);
    int lo;
    int v;
    lo = xs - 3;
    if (c <= lo || c > xe - 3) return 0;
    v = (c - lo) / s;
    return (v > 239) ? 239 : v;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge pxlClk);
    #1;
    checks++; if (drawWin !== 1'b0) begin failures++; $display("FAIL reset_drawWin got %0d want 0", drawWin); end
    checks++; if (subX !== 3'd0) begin failures++; $display("FAIL reset_subX got %0d want 0", subX); end
    checks++; if (subY !== 3'd0) begin failures++; $display("FAIL reset_subY got %0d want 0", subY); end
    checks++; if (curPxl !== 8'd0) begin failures++; $display("FAIL reset_curPxl got %0d want 0", curPxl); end
    checks++; if (nextLine !== 1'b0) begin failures++; $display("FAIL reset_nextLine got %0d want 0", nextLine); end
    checks++; if (cacheUpdate !== 1'b0) begin failures++; $display("FAIL reset_cacheUpdate got %0d want 0", cacheUpdate); end
    checks++; if (hdmiEnable !== 1'b0) begin failures++; $display("FAIL reset_hdmiEnable got %0d want 0", hdmiEnable); end
    checks++; if (activeScale !== 4'd3) begin failures++; $display("FAIL reset_activeScale got %0d want 3", activeScale); end
    rst = 1'b1;
    tick(0, 0);
  endtask

  task automatic test_scale3();
    int ys[4];
    int xs[4];
    bit exp;
    ys = '{119, 120, 599, 600};
    xs = '{279, 280, 999, 1000};
    scaleSel = 3'd2;
    frameEndTick();
    frameEndTick();
    checks++; if (activeScale !== 4'd3) begin failures++; $display("FAIL s3_activeScale got %0d want 3", activeScale); end
    newFrameIn = 1'b1; tick(0, 0);
    newFrameIn = 1'b0; tick(1, 0);
    checks++; if (hdmiEnable !== 1'b1) begin failures++; $display("FAIL s3_lock got %0d want 1", hdmiEnable); end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        tick(xs[j], ys[i]);
        exp = (xs[j] >= 280 && xs[j] < 1000 && ys[i] >= 120 && ys[i] < 600);
        checks++; if (drawWin !== exp) begin failures++; $display("FAIL s3_win x=%0d y=%0d got %0d want %0d", xs[j], ys[i], drawWin, exp); end
      end
    end
    for (int c = 270; c <= 1010; c++) begin
      tick(c, 120);
      exp = (c >= 280 && c < 1000);
      checks++; if (drawWin !== exp) begin failures++; $display("FAIL s3_sweep_win x=%0d got %0d want %0d", c, drawWin, exp); end
      checks++; if (int'(curPxl) != expCurPxl(c, 280, 1000, 3)) begin failures++; $display("FAIL s3_curPxl x=%0d got %0d want %0d", c, curPxl, expCurPxl(c, 280, 1000, 3)); end
      checks++; if (cacheUpdate !== (c == 1000)) begin failures++; $display("FAIL s3_cacheUpdate x=%0d got %0d want %0d", c, cacheUpdate, c == 1000); end
      if (c >= 280) begin
        checks++; if (int'(subX) != (c - 280) % 3) begin failures++; $display("FAIL s3_subX x=%0d got %0d want %0d", c, subX, (c - 280) % 3); end
      end
    end
  endtask

  task automatic test_nextline();
    int es;
    bit en;
    frameEndTick();
    for (int y = 118; y <= 130; y++) begin
      sameLine = (y == 125);
      tick(1000, y);
      es = (y < 120) ? 0 : (y - 120) % 3;
      en = (es == 2) && (y != 125);
      checks++; if (int'(subY) != es) begin failures++; $display("FAIL nl_subY y=%0d got %0d want %0d", y, subY, es); end
      checks++; if (cacheUpdate !== 1'b1) begin failures++; $display("FAIL nl_cacheUpdate y=%0d got %0d want 1", y, cacheUpdate); end
      checks++; if (nextLine !== en) begin failures++; $display("FAIL nl_nextLine y=%0d got %0d want %0d", y, nextLine, en); end
      sameLine = 1'b0;
      tick(1649, y);
      checks++; if (nextLine !== 1'b0) begin failures++; $display("FAIL nl_nextLine_off y=%0d got %0d want 0", y, nextLine); end
    end
  endtask

  task automatic test_scale_change();
    int es;
    bit exp;
    tick(500, 299);
    scaleSel = 3'd3;
    tick(500, 300);
    checks++; if (activeScale !== 4'd3) begin failures++; $display("FAIL sc_midframe_scale got %0d want 3", activeScale); end
    tick(280, 300);
    checks++; if (drawWin !== 1'b1) begin failures++; $display("FAIL sc_old_x280 got %0d want 1", drawWin); end
    tick(160, 300);
    checks++; if (drawWin !== 1'b0) begin failures++; $display("FAIL sc_old_x160 got %0d want 0", drawWin); end
    tick(1119, 300);
    checks++; if (drawWin !== 1'b0) begin failures++; $display("FAIL sc_old_x1119 got %0d want 0", drawWin); end
    frameEndTick();
    checks++; if (activeScale !== 4'd4) begin failures++; $display("FAIL sc_new_scale got %0d want 4", activeScale); end
    for (int c = 150; c <= 175; c++) begin
      tick(c, 40);
      exp = (c >= 160);
      checks++; if (drawWin !== exp) begin failures++; $display("FAIL sc_win x=%0d got %0d want %0d", c, drawWin, exp); end
      checks++; if (int'(curPxl) != expCurPxl(c, 160, 1120, 4)) begin failures++; $display("FAIL sc_curPxl x=%0d got %0d want %0d", c, curPxl, expCurPxl(c, 160, 1120, 4)); end
      if (c >= 160) begin
        checks++; if (int'(subX) != (c - 160) % 4) begin failures++; $display("FAIL sc_subX x=%0d got %0d want %0d", c, subX, (c - 160) % 4); end
      end
    end
    tick(160, 39);
    checks++; if (drawWin !== 1'b0) begin failures++; $display("FAIL sc_y39 got %0d want 0", drawWin); end
    tick(1119, 679);
    checks++; if (drawWin !== 1'b1) begin failures++; $display("FAIL sc_corner got %0d want 1", drawWin); end
    tick(1120, 679);
    checks++; if (drawWin !== 1'b0) begin failures++; $display("FAIL sc_x1120 got %0d want 0", drawWin); end
    tick(500, 680);
    checks++; if (drawWin !== 1'b0) begin failures++; $display("FAIL sc_y680 got %0d want 0", drawWin); end
    frameEndTick();
    for (int y = 38; y <= 49; y++) begin
      tick(1120, y);
      es = (y < 40) ? 0 : (y - 40) % 4;
      checks++; if (int'(subY) != es) begin failures++; $display("FAIL sc_subY y=%0d got %0d want %0d", y, subY, es); end
      checks++; if (nextLine !== (es == 3)) begin failures++; $display("FAIL sc_nextLine y=%0d got %0d want %0d", y, nextLine, es == 3); end
      tick(1649, y);
    end
  endtask

  // Force a resync, then present another rise `gap` edges after the resync edge.
  task automatic doResync(input int gap, input bit expLock);
    newFrameIn = 1'b1; tick(0, 400);
    newFrameIn = 1'b0;
    checks++; if (hdmiEnable !== 1'b0) begin failures++; $display("FAIL rs_enter gap=%0d got %0d want 0", gap, hdmiEnable); end
    for (int i = 1; i < gap; i++) begin
      tick(i, 400);
      checks++; if (hdmiEnable !== 1'b0) begin failures++; $display("FAIL rs_hold gap=%0d cyc=%0d got %0d want 0", gap, i, hdmiEnable); end
    end
    newFrameIn = 1'b1; tick(0, 400);
    newFrameIn = 1'b0; tick(1, 400);
    checks++; if (hdmiEnable !== expLock) begin failures++; $display("FAIL rs_rise gap=%0d got %0d want %0d", gap, hdmiEnable, expLock); end
    if (!expLock) begin
      newFrameIn = 1'b1; tick(2, 400);
      newFrameIn = 1'b0; tick(3, 400);
      checks++; if (hdmiEnable !== 1'b1) begin failures++; $display("FAIL rs_relock gap=%0d got %0d want 1", gap, hdmiEnable); end
    end
  endtask

  task automatic test_resync();
    checks++; if (hdmiEnable !== 1'b1) begin failures++; $display("FAIL rs_pre got %0d want 1", hdmiEnable); end
    newFrameIn = 1'b1; tick(0, 39);
    newFrameIn = 1'b0; tick(1, 39);
    checks++; if (hdmiEnable !== 1'b1) begin failures++; $display("FAIL rs_ystart_m1 got %0d want 1", hdmiEnable); end
    newFrameIn = 1'b1; tick(0, 40);
    newFrameIn = 1'b0; tick(1, 40);
    checks++; if (hdmiEnable !== 1'b1) begin failures++; $display("FAIL rs_ystart got %0d want 1", hdmiEnable); end
    doResync(16, 1'b0);
    doResync(17, 1'b1);
  endtask

  // Frame-end latch and rise together: rise judged against the old yStart (40).
  task automatic test_simul();
    scaleSel = 3'd2;
    frameHeight = 11'd41;
    newFrameIn = 1'b1; tick(1649, 40);
    newFrameIn = 1'b0;
    frameHeight = 11'd750;
    tick(0, 0);
    checks++; if (hdmiEnable !== 1'b1) begin failures++; $display("FAIL simul_locked got %0d want 1", hdmiEnable); end
    checks++; if (activeScale !== 4'd3) begin failures++; $display("FAIL simul_scale got %0d want 3", activeScale); end
  endtask

  task automatic test_clamp_and_reset();
    scaleSel = 3'd7;
    frameEndTick();
    checks++; if (activeScale !== 4'd4) begin failures++; $display("FAIL clamp_scale got %0d want 4", activeScale); end
    tick(499, 300);
    tick(500, 300);
    checks++; if (drawWin !== 1'b1) begin failures++; $display("FAIL mid_drawWin got %0d want 1", drawWin); end
    checks++; if (hdmiEnable !== 1'b1) begin failures++; $display("FAIL mid_hdmiEnable got %0d want 1", hdmiEnable); end
    #2 rst = 1'b0;
    #1;
    checks++; if (drawWin !== 1'b0) begin failures++; $display("FAIL async_drawWin got %0d want 0", drawWin); end
    checks++; if (subX !== 3'd0) begin failures++; $display("FAIL async_subX got %0d want 0", subX); end
    checks++; if (curPxl !== 8'd0) begin failures++; $display("FAIL async_curPxl got %0d want 0", curPxl); end
    checks++; if (hdmiEnable !== 1'b0) begin failures++; $display("FAIL async_hdmiEnable got %0d want 0", hdmiEnable); end
    checks++; if (activeScale !== 4'd3) begin failures++; $display("FAIL async_activeScale got %0d want 3", activeScale); end
    #2 rst = 1'b1;
    scaleSel = 3'd2;
    tick(500, 300);
    checks++; if (drawWin !== 1'b0) begin failures++; $display("FAIL idle_drawWin got %0d want 0", drawWin); end
    checks++; if (hdmiEnable !== 1'b0) begin failures++; $display("FAIL idle_hdmiEnable got %0d want 0", hdmiEnable); end
  endtask

`ifdef RESYNC_STATS_EN
  task automatic test_stats();
    int want;
    checks++; if (resyncCount !== 8'd0) begin failures++; $display("FAIL stats_init got %0d want 0", resyncCount); end
    for (int i = 1; i <= 300; i++) begin
      newFrameIn = 1'b1; tick(0, 0);
      newFrameIn = 1'b0; tick(1, 0);
      newFrameIn = 1'b1; tick(0, 400);
      newFrameIn = 1'b0;
      repeat (17) tick(5, 400);
      if (i == 1 || i == 254 || i == 255 || i == 300) begin
        want = (i > 255) ? 255 : i;
        checks++; if (int'(resyncCount) != want) begin failures++; $display("FAIL stats_count n=%0d got %0d want %0d", i, resyncCount, want); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scale3();
    test_nextline();
    test_scale_change();
    test_resync();
    test_simul();
    test_clamp_and_reset();
`ifdef RESYNC_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
